jk_cmd_driver: RTL
==================

// Module: jk_cmd_driver
// PURPOSE
//  Upstream stimulus stage for the JK flip-flop: takes queued commands (op + hold length),
//  drives the flop's j/k pins for the requested cycles, then returns to hold (j=k=0).
//  Keeps a cycle-aligned reference model of q (exp_q) for the scoreboard to check.
//  Sits between the test environment and the JK flop DUT; its j/k wire directly to DUT j/k.
// PARAMETERS
//  DEPTH  4  command FIFO entries; power of 2, >=2
//  LEN_W  4  width of hold-length field; one command drives 1..2**LEN_W cycles
// PORTS
//  clk        in   1                  clock, all state on rising edge
//  rst        in   1                  async reset, active-high; DUT rstn = ~rst
//  cmd_valid  in   1                  command offered
//  cmd_ready  out  1                  FIFO can accept
//  cmd_op     in   2                  00 HOLD, 01 CLR(j0k1), 10 SET(j1k0), 11 TOGGLE(j1k1)
//  cmd_len    in   LEN_W              op held for cmd_len+1 cycles
//  j          out  1                  to DUT j, registered
//  k          out  1                  to DUT k, registered
//  busy       out  1                  1 while a command is being driven
//  exp_q      out  1                  model of DUT q after each edge
//  fifo_count out  $clog2(DEPTH)+1    queued, not-yet-started commands
// BEHAVIOUR
//  - Reset (async assert, sync-to-clk deassert by driver): FIFO emptied, j=k=0, busy=0,
//    exp_q=0, fifo_count=0, FSM=IDLE. Mid-operation reset discards active and queued cmds.
//  - cmd_ready = (fifo_count < DEPTH); registered count only, no same-cycle pop bypass.
//    Push on rising edge with cmd_valid & cmd_ready. Pointers wrap mod DEPTH.
//  - FSM IDLE: if FIFO non-empty, pop head, load j/k from op, rem<=len, go DRIVE.
//    Latency: accepted at edge N -> j/k valid after edge N+1. Empty -> stay, j=k=0.
//  - FSM DRIVE: j/k held; each edge rem<=rem-1. At edge with rem==0: FIFO non-empty ->
//    pop next, reload (back-to-back, zero gap cycles); else j=k=0, go IDLE.
//  - busy = (state==DRIVE).
//  - Simultaneous push+pop: both take effect; count unchanged. Push+pop when empty:
//    no bypass, pushed cmd starts the following cycle.
//  - exp_q: each edge, exp_q <= JK(exp_q, j, k) using j/k currently on outputs:
//    00 hold, 01 ->0, 10 ->1, 11 ->~exp_q. Matches DUT q edge-for-edge.
//  - HOLD op still occupies len+1 cycles (busy=1, j=k=0) - used as timed idle.
// CONFIGURATION
//  JK_CMD_CHECK_EN defined: adds ports q_in(in,1; DUT q), mismatch(out,1), err_cnt(out,8).
//    Each edge compares q_in vs exp_q; mismatch=1 for one cycle after a differing edge;
//    err_cnt increments per mismatch, saturates at 255. Both reset to 0.
//  Not defined: ports and compare logic absent; all other behaviour identical.
// TESTING
//  1 rst=1 two cycles -> j=k=0, exp_q=0, busy=0, cmd_ready=1, fifo_count=0.
//  2 push SET len=2 at edge N -> j=1,k=0 edges N+1..N+3, busy 3 cycles, exp_q=1, then j=k=0.
//  3 push TOGGLE len=0 then TOGGLE len=3 back-to-back -> j=k=1 for 5 contiguous cycles,
//    no gap, exp_q toggles 5x, ends 1.
//  4 DEPTH=4, hold cmd_valid, first cmd SET len=15 -> 5 accepted, fifo_count=4,
//    cmd_ready=0 until first cmd finishes, then one slot frees per completed cmd.
//  5 rst pulse during DRIVE with 3 queued -> j=k=0, busy=0, fifo_count=0 immediately;
//    queued cmds never execute; exp_q=0.
//  6 JK_CMD_CHECK_EN: invert q_in one cycle during TOGGLE run -> mismatch=1 one cycle,
//    err_cnt=1; 300 forced mismatches -> err_cnt=255.

Source files
------------

// File: rtl/jk_cmd_driver_if.sv
// Command handshake bundle for jk_cmd_driver: a beat transfers when cmd_valid and
// cmd_ready are both high at a rising clk edge; cmd_op/cmd_len must be stable while cmd_valid is high.
interface jk_cmd_driver_if #(
  parameter int LEN_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [LEN_W-1:0] cmd_len;

  modport master (output cmd_valid, output cmd_op, output cmd_len, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_len, output cmd_ready);
endinterface

// File: rtl/jk_cmd_driver.sv
// JK flop stimulus driver: queues op/length commands, drives j/k for len+1 cycles each and
// tracks a reference q (exp_q). Define JK_CMD_CHECK_EN to add q_in compare, mismatch and err_cnt.
module jk_cmd_driver #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  jk_cmd_driver_if.slave         cmd,
  output logic                   j,
  output logic                   k,
  output logic                   busy,
  output logic                   exp_q,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   fsm_state
`ifdef JK_CMD_CHECK_EN
  ,
  input  logic                   q_in,
  output logic                   mismatch,
  output logic [7:0]             err_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = LEN_W + 2;

  typedef enum logic {IDLE = 1'b0, DRIVE = 1'b1} state_t;

  state_t           state;
  logic [LEN_W-1:0] rem;
  logic [EW-1:0]    mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;
  logic             has_cmd;
  logic [1:0]       head_op;
  logic [LEN_W-1:0] head_len;

  // Ready comes from the registered count only; a pop in the same cycle does not free a slot early.
  assign cmd.cmd_ready = (count < CW'(DEPTH));
  assign push          = cmd.cmd_valid & cmd.cmd_ready;
  assign has_cmd       = (count != '0);
  assign pop           = has_cmd & ((state == IDLE) | (rem == '0));
  assign head_op       = mem[rd_ptr][EW-1:LEN_W];
  assign head_len      = mem[rd_ptr][LEN_W-1:0];

  assign busy       = (state == DRIVE);
  assign fsm_state  = state;
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd.cmd_op, cmd.cmd_len};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // op bit 1 drives j and bit 0 drives k, so HOLD/CLR/SET/TOGGLE map straight onto the pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      j     <= 1'b0;
      k     <= 1'b0;
      rem   <= '0;
      exp_q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   exp_q <= 1'b0;
        2'b10:   exp_q <= 1'b1;
        2'b11:   exp_q <= ~exp_q;
        default: exp_q <= exp_q;
      endcase

      case (state)
        IDLE: begin
          if (has_cmd) begin
            j     <= head_op[1];
            k     <= head_op[0];
            rem   <= head_len;
            state <= DRIVE;
          end else begin
            j <= 1'b0;
            k <= 1'b0;
          end
        end
        DRIVE: begin
          if (rem != '0) begin
            rem <= rem - LEN_W'(1);
          end else if (has_cmd) begin
            j   <= head_op[1];
            k   <= head_op[0];
            rem <= head_len;
          end else begin
            j     <= 1'b0;
            k     <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef JK_CMD_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch <= 1'b0;
      err_cnt  <= 8'd0;
    end else begin
      mismatch <= (q_in != exp_q);
      if ((q_in != exp_q) && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule
